// File: rtl/unified_memory_arbiter_if.sv
// Bus bundle for the unified memory arbiter: the IF and MEM requester
// handshakes, the single RAM port, and the stall / performance outputs.
// The arbiter uses the slave modport; the requesters and RAM model use master.
interface unified_memory_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // instruction-fetch requester
   logic                  if_req;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic [DATA_WIDTH-1:0] if_rdata;
   logic                  if_valid;
   // data-memory requester
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_valid;
   // unified RAM port
   logic                  ram_en;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;
   // pipeline stall feedback and performance counter
   logic                  stall_if;
   logic                  stall_mem;
   logic [31:0]           stall_cycles;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      output if_rdata, if_valid, mem_rdata, mem_valid,
             ram_en, ram_we, ram_addr, ram_wdata,
             stall_if, stall_mem, stall_cycles
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      input  if_rdata, if_valid, mem_rdata, mem_valid,
             ram_en, ram_we, ram_addr, ram_wdata,
             stall_if, stall_mem, stall_cycles
   );
endinterface

// File: rtl/unified_memory_arbiter.sv
// Shares one single-ported, fixed-latency RAM between instruction fetch (IF)
// and data memory (MEM). One access is in flight at a time; MEM wins
// conflicts unless IF has lost FETCH_STARVE_LIMIT conflicts in a row.
module unified_memory_arbiter #(
   parameter int ADDR_WIDTH         = 32,
   parameter int DATA_WIDTH         = 32,
   parameter int MEM_LATENCY        = 1,
   parameter int FETCH_STARVE_LIMIT = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   unified_memory_arbiter_if.slave bus_io
);
   localparam int LAT_W = $clog2(MEM_LATENCY + 1);
   localparam int STV_W = $clog2(FETCH_STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                state_q;
   logic                  owner_mem_q;     // 1: MEM owns the access, 0: IF
   logic [LAT_W-1:0]      lat_q;
   logic [STV_W-1:0]      starve_q;
   logic                  ram_en_q;
   logic                  ram_we_q;
   logic [ADDR_WIDTH-1:0] ram_addr_q;
   logic [DATA_WIDTH-1:0] ram_wdata_q;
   logic                  if_valid_q;
   logic                  mem_valid_q;
   logic [DATA_WIDTH-1:0] if_rdata_q;
   logic [DATA_WIDTH-1:0] mem_rdata_q;
   logic [31:0]           stall_cycles_q;
   logic [31:0]           stall_cycles_d;

   logic                  if_elig;
   logic                  mem_elig;
   logic                  starved;
   logic                  grant_mem;
   logic                  stall_if;
   logic                  stall_mem;

   // Eligibility, arbitration choice, stall flags and saturating stall count
   always_comb begin
      // A requester completing this cycle still holds req; it must not be re-granted.
      if_elig   = bus_io.if_req  & ~if_valid_q;
      mem_elig  = bus_io.mem_req & ~mem_valid_q;
      starved   = (starve_q == STV_W'(FETCH_STARVE_LIMIT));
      grant_mem = mem_elig & ~(if_elig & starved);
      stall_if  = bus_io.if_req  & ~if_valid_q;
      stall_mem = bus_io.mem_req & ~mem_valid_q;
      stall_cycles_d = stall_cycles_q;
      if ((stall_if | stall_mem) && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
   end

   // Access sequencer: grant in IDLE, strobe RAM in ISSUE, count latency in WAIT, pulse valid in DONE
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_mem_q <= 1'b0;
         lat_q       <= '0;
         starve_q    <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (if_elig | mem_elig) begin
                  owner_mem_q <= grant_mem;
                  ram_en_q    <= 1'b1;
                  state_q     <= ISSUE;
                  if (grant_mem) begin
                     ram_we_q    <= bus_io.mem_we;
                     ram_addr_q  <= bus_io.mem_addr;
                     ram_wdata_q <= bus_io.mem_wdata;
                     // Only a real conflict counts against fetch.
                     if (if_elig) begin
                        starve_q <= starve_q + STV_W'(1);
                     end
                  end else begin
                     ram_we_q    <= 1'b0;
                     ram_addr_q  <= bus_io.if_addr;
                     ram_wdata_q <= '0;
                     starve_q    <= '0;
                  end
               end
            end
            ISSUE: begin
               ram_en_q <= 1'b0;
               lat_q    <= LAT_W'(MEM_LATENCY);
               state_q  <= WAIT;
            end
            WAIT: begin
               if (lat_q == LAT_W'(1)) begin
                  state_q <= DONE;
                  if (owner_mem_q) begin
                     mem_valid_q <= 1'b1;
                     // Stores complete with a pulse but leave the load result untouched.
                     if (!ram_we_q) begin
                        mem_rdata_q <= bus_io.ram_rdata;
                     end
                  end else begin
                     if_valid_q <= 1'b1;
                     if_rdata_q <= bus_io.ram_rdata;
                  end
               end else begin
                  lat_q <= lat_q - LAT_W'(1);
               end
            end
            DONE: begin
               if_valid_q  <= 1'b0;
               mem_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Stall-cycle performance counter
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign bus_io.ram_en       = ram_en_q;
   assign bus_io.ram_we       = ram_we_q;
   assign bus_io.ram_addr     = ram_addr_q;
   assign bus_io.ram_wdata    = ram_wdata_q;
   assign bus_io.if_rdata     = if_rdata_q;
   assign bus_io.if_valid     = if_valid_q;
   assign bus_io.mem_rdata    = mem_rdata_q;
   assign bus_io.mem_valid    = mem_valid_q;
   assign bus_io.stall_if     = stall_if;
   assign bus_io.stall_mem    = stall_mem;
   assign bus_io.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Bench for unified_memory_arbiter: two instances (MEM_LATENCY 1 and 3), each
// with a simple RAM model whose read data is valid only MEM_LATENCY cycles
// after the enable. A transaction-level timeline model predicts every output.
module tb_unified_memory_arbiter;
   localparam int STARVE = 4;

   logic clock    = 1'b0;
   logic reset    = 1'b1;
   logic ram_init = 1'b0;
   always #5 clock = ~clock;

   logic        if_req    [2];
   logic [31:0] if_addr   [2];
   logic        mem_req   [2];
   logic        mem_we    [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] if_rdata  [2];
   logic        if_valid  [2];
   logic [31:0] mem_rdata [2];
   logic        mem_valid [2];
   logic        ram_en    [2];
   logic        ram_we    [2];
   logic [31:0] ram_addr  [2];
   logic [31:0] ram_wdata [2];
   logic        stall_if  [2];
   logic        stall_mem [2];
   logic [31:0] stall_cycles [2];

   function automatic logic [31:0] init_val(input int k);
      return 32'h2402000A + (32'(k ^ 16) << 12);
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         localparam int LAT = (gi == 0) ? 1 : 3;
         unified_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
         logic [31:0] ram_mem [256];
         logic [31:0] pipe    [LAT];

         assign bus.if_req    = if_req[gi];
         assign bus.if_addr   = if_addr[gi];
         assign bus.mem_req   = mem_req[gi];
         assign bus.mem_we    = mem_we[gi];
         assign bus.mem_addr  = mem_addr[gi];
         assign bus.mem_wdata = mem_wdata[gi];
         assign bus.ram_rdata = pipe[LAT-1];
         assign if_rdata[gi]     = bus.if_rdata;
         assign if_valid[gi]     = bus.if_valid;
         assign mem_rdata[gi]    = bus.mem_rdata;
         assign mem_valid[gi]    = bus.mem_valid;
         assign ram_en[gi]       = bus.ram_en;
         assign ram_we[gi]       = bus.ram_we;
         assign ram_addr[gi]     = bus.ram_addr;
         assign ram_wdata[gi]    = bus.ram_wdata;
         assign stall_if[gi]     = bus.stall_if;
         assign stall_mem[gi]    = bus.stall_mem;
         assign stall_cycles[gi] = bus.stall_cycles;

         unified_memory_arbiter #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32),
            .MEM_LATENCY(LAT), .FETCH_STARVE_LIMIT(STARVE)
         ) u_dut (
            .clock  (clock),
            .reset  (reset),
            .bus_io (bus)
         );

         // RAM model: read data appears exactly LAT cycles after the enable, garbage otherwise
         always @(posedge clock) begin
            if (ram_init) begin
               for (int k = 0; k < 256; k++) ram_mem[k] <= init_val(k);
            end else if (bus.ram_en && bus.ram_we) begin
               ram_mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
            end
            pipe[0] <= bus.ram_en ? ram_mem[bus.ram_addr[9:2]] : 32'h0BAD0BAD;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
         end
      end
   endgenerate

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          ln       = 0;
   int          mode     = 0;   // 0: directed only, 1: random, 2: both always re-request
   // requester intent
   bit          if_pend, mem_pend, mem_pw;
   logic [31:0] if_pa, mem_pa, mem_pd;
   // reference model
   int          m_idle_at, m_done_at, m_grant_at, m_starve;
   bit          m_owner_mem, m_we, exp_ram_we;
   logic [31:0] m_if_data, m_mem_data, exp_if_rdata, exp_mem_rdata;
   logic [31:0] exp_ram_addr, exp_ram_wdata, exp_cnt;
   logic [31:0] m_mem [int];
   // observed events for directed checks
   int          obs_ifv, obs_memv, obs_memv_n;
   logic [31:0] obs_if_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h (cycle %0d lane %0d)", tag, obs, expv, cyc, ln);
      end
   endtask

   function automatic logic [31:0] mread(input int idx);
      return m_mem.exists(idx) ? m_mem[idx] : init_val(idx);
   endfunction

   task automatic model_clear(input int idle_from);
      m_idle_at = idle_from; m_done_at = -100; m_grant_at = -100; m_starve = 0;
      m_owner_mem = 0; m_we = 0; exp_ram_we = 0;
      exp_if_rdata = '0; exp_mem_rdata = '0; exp_ram_addr = '0; exp_ram_wdata = '0; exp_cnt = '0;
   endtask

   task automatic obs_clear();
      obs_ifv = -1; obs_memv = -1; obs_memv_n = 0; obs_if_data = '0;
   endtask

   // One clock cycle: drive, compare against the model, advance the model past the edge
   task automatic step(input bit do_rst);
      int L, idx;
      bit e_ifv, e_memv, e_en, e_sif, e_smem, el_if, el_mem, win_mem;
      L = (ln == 0) ? 1 : 3;
      reset = do_rst;
      if_req[ln] = if_pend;   if_addr[ln] = if_pa;
      mem_req[ln] = mem_pend; mem_we[ln] = mem_pw; mem_addr[ln] = mem_pa; mem_wdata[ln] = mem_pd;
      #1;
      e_ifv  = (cyc == m_done_at) && !m_owner_mem;
      e_memv = (cyc == m_done_at) &&  m_owner_mem;
      e_en   = (cyc == m_grant_at + 1);
      e_sif  = if_pend  && !e_ifv;
      e_smem = mem_pend && !e_memv;
      if (e_ifv) exp_if_rdata = m_if_data;
      if (e_memv && !m_we) exp_mem_rdata = m_mem_data;
      chk("if_valid",     32'(if_valid[ln]),  32'(e_ifv));
      chk("mem_valid",    32'(mem_valid[ln]), 32'(e_memv));
      chk("ram_en",       32'(ram_en[ln]),    32'(e_en));
      chk("ram_we",       32'(ram_we[ln]),    32'(exp_ram_we));
      chk("ram_addr",     ram_addr[ln],       exp_ram_addr);
      chk("ram_wdata",    ram_wdata[ln],      exp_ram_wdata);
      chk("if_rdata",     if_rdata[ln],       exp_if_rdata);
      chk("mem_rdata",    mem_rdata[ln],      exp_mem_rdata);
      chk("stall_if",     32'(stall_if[ln]),  32'(e_sif));
      chk("stall_mem",    32'(stall_mem[ln]), 32'(e_smem));
      chk("stall_cycles", stall_cycles[ln],   exp_cnt);
      if (if_valid[ln] && obs_ifv < 0) begin obs_ifv = cyc; obs_if_data = if_rdata[ln]; end
      if (mem_valid[ln]) begin
         if (obs_memv < 0) obs_memv = cyc;
         obs_memv_n++;
      end
      if (do_rst) begin
         if_pend = 0; mem_pend = 0;
         model_clear(cyc + 1);
      end else begin
         if (e_sif || e_smem) exp_cnt = exp_cnt + 32'd1;
         if (cyc >= m_idle_at) begin
            el_if  = if_pend  && !e_ifv;
            el_mem = mem_pend && !e_memv;
            if (el_if || el_mem) begin
               win_mem = el_mem && !(el_if && m_starve == STARVE);
               m_grant_at = cyc; m_done_at = cyc + L + 2; m_idle_at = cyc + L + 3;
               m_owner_mem = win_mem;
               if (win_mem) begin
                  if (el_if) m_starve++;
                  idx = int'(mem_pa[9:2]);
                  exp_ram_addr = mem_pa; exp_ram_we = mem_pw; exp_ram_wdata = mem_pd; m_we = mem_pw;
                  if (mem_pw) m_mem[idx] = mem_pd;
                  else m_mem_data = mread(idx);
               end else begin
                  m_starve = 0;
                  idx = int'(if_pa[9:2]);
                  exp_ram_addr = if_pa; exp_ram_we = 0; exp_ram_wdata = '0; m_we = 0;
                  m_if_data = mread(idx);
               end
            end
         end
         if (e_ifv)  if_pend  = 0;
         if (e_memv) mem_pend = 0;
         if (!if_pend && (mode == 2 || (mode == 1 && $urandom_range(0, 3) != 0))) begin
            if_pend = 1; if_pa = 32'($urandom_range(0, 31)) << 2;
         end
         if (!mem_pend && (mode == 2 || (mode == 1 && $urandom_range(0, 3) != 0))) begin
            mem_pend = 1;
            mem_pw = (mode == 1) && ($urandom_range(0, 1) == 1);
            mem_pa = 32'($urandom_range(0, 31)) << 2;
            mem_pd = $urandom;
         end
      end
      @(negedge clock);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   initial begin
      int t0;
      logic [31:0] base;
      for (int i = 0; i < 2; i++) begin
         if_req[i] = 0; if_addr[i] = '0; mem_req[i] = 0; mem_we[i] = 0;
         mem_addr[i] = '0; mem_wdata[i] = '0;
      end
      if_pend = 0; mem_pend = 0; mem_pw = 0; if_pa = '0; mem_pa = '0; mem_pd = '0;
      reset = 1; ram_init = 1;
      @(negedge clock);
      ram_init = 0;
      @(negedge clock);
      ln = 0; mode = 0; model_clear(cyc); obs_clear();

      // reset state
      run(2);

      // single fetch of 0x40
      obs_clear(); base = exp_cnt; t0 = cyc;
      if_pend = 1; if_pa = 32'h40;
      run(6);
      chk("t1_ifv_cycle",     32'(obs_ifv - t0), 32'd3);
      chk("t1_if_rdata",      obs_if_data,       32'h2402000A);
      chk("t1_stall_cycles",  stall_cycles[0],   base + 32'd3);

      // store then load at 0x100
      obs_clear();
      mem_pend = 1; mem_pw = 1; mem_pa = 32'h100; mem_pd = 32'hDEADBEEF;
      run(5);
      mem_pend = 1; mem_pw = 0;
      run(5);
      chk("t2_memv_count", 32'(obs_memv_n), 32'd2);
      chk("t2_load_data",  mem_rdata[0],    32'hDEADBEEF);

      // simultaneous requests: MEM first, IF next
      obs_clear(); t0 = cyc;
      mem_pend = 1; mem_pw = 0; mem_pa = 32'h104;
      if_pend = 1; if_pa = 32'h48;
      run(9);
      chk("t3_memv_cycle", 32'(obs_memv - t0), 32'd3);
      chk("t3_ifv_cycle",  32'(obs_ifv - t0),  32'd7);
      chk("t3_memv_count", 32'(obs_memv_n),    32'd1);

      // starvation guard: IF wins its fifth conflict
      obs_clear(); t0 = cyc; mode = 2;
      if_pend = 1; if_pa = 32'h4C;
      mem_pend = 1; mem_pw = 0; mem_pa = 32'h108;
      run(40);
      chk("t4_ifv_cycle", 32'(obs_ifv - t0), 32'd19);
      mode = 0;
      run(12);

      // reset while WAIT: no pulse, everything back to reset values
      obs_clear();
      if_pend = 1; if_pa = 32'h44;
      run(2);
      step(1'b1);
      chk("t5_ram_en",       32'(ram_en[0]),   32'd0);
      chk("t5_if_valid",     32'(if_valid[0]), 32'd0);
      chk("t5_ram_addr",     ram_addr[0],      32'd0);
      chk("t5_stall_cycles", stall_cycles[0],  32'd0);
      run(4);
      chk("t5_no_pulse", 32'(obs_ifv), 32'hFFFF_FFFF);
      obs_clear(); t0 = cyc;
      if_pend = 1; if_pa = 32'h44;
      run(6);
      chk("t5_reissue_cycle", 32'(obs_ifv - t0), 32'd3);
      chk("t5_reissue_data",  obs_if_data,       init_val(17));

      // random traffic, latency 1
      mode = 1;
      run(300);
      mode = 0;
      run(14);

      // switch to the MEM_LATENCY=3 instance
      if_req[0] = 0; mem_req[0] = 0;
      ln = 1; m_mem.delete(); model_clear(cyc);
      obs_clear(); t0 = cyc;
      if_pend = 1; if_pa = 32'h40;
      run(8);
      chk("t6_ifv_cycle", 32'(obs_ifv - t0), 32'd5);
      chk("t6_if_rdata",  obs_if_data,       32'h2402000A);
      mode = 1;
      run(200);
      mode = 0;
      run(14);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
